// File: rtl/disp_pkg.sv
// disp_pkg: shared types, constants and digit-selection helper for the display blocks.
package disp_pkg;
   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
   localparam int DIGITS_DEF = 8;
   localparam logic [6:0] CA_OFF = 7'h7F;
   localparam logic [7:0] AN_OFF = 8'hFF;
   // First set bit of mask strictly after idx, wrapping modulo n; idx itself if it is the only one.
   function automatic int next_enabled(input logic [31:0] mask, input int idx, input int n = DIGITS_DEF);
      int r;
      int j;
      r = idx;
      for (int k = n; k >= 1; k--) begin
         j = (idx + k) % n;
         if (mask[j[4:0]]) r = j;
      end
      return r;
   endfunction
endpackage

// File: rtl/disp_scan_ctrl_tick_gen.sv
// tick_gen: free-running 2^N prescaler with synchronous clear and terminal-count flag.
module tick_gen #(
   parameter int N = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tc
);
   logic [N-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : cnt_q + N'(1);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
   assign tc = &cnt_q;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: round-robin seven-segment scan with blanking gaps and per-slot pattern latch.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int N         = 1,
   parameter int DIGITS    = DIGITS_DEF,
   parameter int BLANK_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [DIGITS-1:0]     dig_en,
   input  logic [7*DIGITS-1:0]   seg_data,
   output logic [6:0]            CA,
   output logic [DIGITS-1:0]     AN,
   output logic                  frame_start
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int BW = BLANK_CYC > 1 ? $clog2(BLANK_CYC) : 1;
   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [6:0]      held_q, held_d;
   logic [BW-1:0]   bl_q, bl_d;
   logic            fs_q, fs_d;
   logic            tc, bl_done, sel;
   int              low, nxt;

   tick_gen #(.N(N)) u_tick (
      .clk (clk),
      .rst (rst),
      .clr (state_q != SHOW || !en),
      .tc  (tc)
   );

   assign bl_done = bl_q == BW'(BLANK_CYC - 1);
   // dig_en only matters at the instant a new slot is chosen
   assign sel = en && dig_en != '0 && (state_q == IDLE || (state_q == BLANK && bl_done));

   always_comb begin
      low     = next_enabled(32'(dig_en), DIGITS - 1, DIGITS);
      nxt     = state_q == IDLE ? low : next_enabled(32'(dig_en), int'(idx_q), DIGITS);
      state_d = state_q;
      idx_d   = idx_q;
      held_d  = held_q;
      bl_d    = '0;
      fs_d    = 1'b0;
      if (!en) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (sel) begin
         state_d = SHOW;
         idx_d   = IW'(nxt);
         held_d  = 7'(seg_data >> (7 * nxt));
         fs_d    = nxt == low;
      end else if (state_q == SHOW && tc) begin
         state_d = BLANK;
      end else if (state_q == BLANK) begin
         state_d = bl_done ? IDLE : BLANK;
         bl_d    = bl_done ? '0 : bl_q + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         held_q  <= '0;
         bl_q    <= '0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         held_q  <= held_d;
         bl_q    <= bl_d;
         fs_q    <= fs_d;
      end
   end

   // Outputs decode only flops, so an anode can be low only while in SHOW
   assign CA          = state_q == SHOW ? ~held_q : CA_OFF;
   assign AN          = ~({{(DIGITS-1){1'b0}}, state_q == SHOW} << idx_q);
   assign frame_start = fs_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for the display scan controller (N=1, 8 digits, 1 blank cycle).
module tb_disp_scan_ctrl;
   import disp_pkg::*;
   typedef struct {logic [7:0] an; logic [6:0] ca; logic fs;} exp_t;

   logic        clk = 1'b0, rst = 1'b0, en = 1'b1;
   logic [7:0]  dig_en = 8'hFF;
   logic [55:0] seg_data = '0;
   logic [6:0]  CA;
   logic [7:0]  AN;
   logic        frame_start;
   exp_t        exp_q[$];
   exp_t        e;
   int          checks = 0, failures = 0, inv_checks = 0, inv_fails = 0;

   disp_scan_ctrl #(.N(1), .DIGITS(8), .BLANK_CYC(1)) dut (
      .clk(clk), .rst(rst), .en(en), .dig_en(dig_en), .seg_data(seg_data),
      .CA(CA), .AN(AN), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst) begin
      inv_checks++;
      if ($countones(~AN) > 1 || (dut.state_q != SHOW && AN !== 8'hFF)) begin
         inv_fails++;
         $display("FAIL invariant: AN=%h state=%0d", AN, dut.state_q);
      end
   end

   function automatic void push_show(int d, logic fs);
      exp_q.push_back('{~(8'd1 << d), ~7'(seg_data >> (7 * d)), fs});
   endfunction

   function automatic void push_off();
      exp_q.push_back('{8'hFF, 7'h7F, 1'b0});
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b1; dig_en = 8'hFF;
      for (int d = 0; d < 8; d++) seg_data[7*d +: 7] = 7'(d * 11 + 3);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({AN, CA, frame_start} !== {8'hFF, 7'h7F, 1'b0}) begin
         failures++;
         $display("FAIL reset_idle: AN=%h CA=%h fs=%b want AN=ff CA=7f fs=0", AN, CA, frame_start);
      end
      rst = 1'b1;
      push_show(0, 1'b1);
      repeat (4) @(negedge clk) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
               failures++;
               $display("FAIL reset_release: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", AN, CA, frame_start, e.an, e.ca, e.fs);
            end
         end
      end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({AN, CA, frame_start} !== {8'hFF, 7'h7F, 1'b0} || dut.state_q !== IDLE) begin
         failures++;
         $display("FAIL async_reset: AN=%h CA=%h fs=%b state=%0d want AN=ff CA=7f fs=0 IDLE", AN, CA, frame_start, dut.state_q);
      end
      @(negedge clk);
      rst = 1'b1;
      push_show(0, 1'b1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
         failures++;
         $display("FAIL reset_restart: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", AN, CA, frame_start, e.an, e.ca, e.fs);
      end
   endtask

   task automatic test_full_scan();
      en = 1'b1; dig_en = 8'hFF;
      for (int d = 0; d < 8; d++) seg_data[7*d +: 7] = 7'(d * 13 + 5);
      do_reset();
      for (int d = 0; d < 8; d++) begin
         push_show(d, d == 0);
         push_show(d, 1'b0);
         push_off();
      end
      push_show(0, 1'b1);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
            failures++;
            $display("FAIL full_scan: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", AN, CA, frame_start, e.an, e.ca, e.fs);
         end
      end
   endtask

   task automatic test_sparse();
      en = 1'b1; dig_en = 8'b0010_0100;
      do_reset();
      repeat (2) begin
         push_show(2, 1'b1); push_show(2, 1'b0); push_off();
         push_show(5, 1'b0); push_show(5, 1'b0); push_off();
      end
      push_show(2, 1'b1);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
            failures++;
            $display("FAIL sparse: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", AN, CA, frame_start, e.an, e.ca, e.fs);
         end
      end
   endtask

   task automatic test_no_tearing();
      en = 1'b1; dig_en = 8'h01; seg_data[6:0] = 7'h3F;
      do_reset();
      exp_q.push_back('{8'hFE, 7'h40, 1'b1});
      exp_q.push_back('{8'hFE, 7'h40, 1'b0});
      exp_q.push_back('{8'hFF, 7'h7F, 1'b0});
      exp_q.push_back('{8'hFE, 7'h79, 1'b1});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
            failures++;
            $display("FAIL no_tearing[%0d]: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", i, AN, CA, frame_start, e.an, e.ca, e.fs);
         end
         if (i == 0) seg_data[6:0] = 7'h06;
      end
   endtask

   task automatic test_back_to_back();
      en = 1'b1; dig_en = 8'hFF;
      for (int d = 0; d < 8; d++) seg_data[7*d +: 7] = 7'(d * 7 + 9);
      do_reset();
      push_show(0, 1'b1);
      push_off(); push_off();
      push_show(0, 1'b1); push_show(0, 1'b0); push_off(); push_show(1, 1'b0);
      push_show(1, 1'b0); push_off(); push_off(); push_off();
      push_show(7, 1'b1);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({AN, CA, frame_start} !== {e.an, e.ca, e.fs}) begin
            failures++;
            $display("FAIL enable_mask[%0d]: AN=%h CA=%h fs=%b want AN=%h CA=%h fs=%b", i, AN, CA, frame_start, e.an, e.ca, e.fs);
         end
         if (i == 0) en = 1'b0;
         if (i == 2) en = 1'b1;
         if (i == 6) dig_en = 8'h00;
         if (i == 10) begin
            checks++;
            if (dut.state_q !== IDLE) begin
               failures++;
               $display("FAIL mask_zero_idle: state=%0d want %0d", dut.state_q, IDLE);
            end
            dig_en = 8'h80;
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_sparse();
      test_no_tearing();
      test_back_to_back();
      checks   += inv_checks;
      failures += inv_fails;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
